// File: rtl/fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a synchronous flush.
module fifo_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;

  logic [CW-1:0]    w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_ok;
  logic             w_rd_ok;

  // Occupancy is the wrap-aware pointer difference; the MSB disambiguates full from empty.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == CW'(0));
  assign w_full  = (w_count == CW'(DEPTH));
  assign w_rd_ok = rd & ~w_empty;
  assign w_wr_ok = wr & (~w_full | w_rd_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[AW'(i)] <= '0;
      end
    end else if (clear) begin
      // Flush leaves the array untouched and swallows any same-cycle request.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= data_in;
        r_wr_ptr                <= r_wr_ptr + CW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + CW'(1);
      end
      if (wr && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (rd && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Show-ahead head entry and status decodes of registered state only.
  assign data_out     = r_mem[r_rd_ptr[AW-1:0]];
  assign count        = w_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (w_count <= CW'(AE_LEVEL));
  assign almost_full  = (w_count >= CW'(AF_LEVEL));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Directed checks of the default 8x8 FIFO plus a queue-model sweep of a 16x32 instance.
module tb_fifo_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear, wr, rd;
  logic [7:0]  data_in, data_out;
  logic        empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0]  count;

  logic        clear_b, wr_b, rd_b;
  logic [15:0] din_b, dout_b;
  logic        empty_b, full_b, ae_b, af_b, ovf_b, udf_b;
  logic [5:0]  count_b;

  int errors = 0;
  int checks = 0;
  logic [7:0]  q_a [$];
  logic [15:0] q_b [$];

  always #5 clk = ~clk;

  fifo_param u_dut (
    .clk(clk), .reset(reset), .clear(clear), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(data_out), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  fifo_param #(.WIDTH(16), .DEPTH(32), .AF_LEVEL(30), .AE_LEVEL(1)) u_dut_b (
    .clk(clk), .reset(reset), .clear(clear_b), .wr(wr_b), .rd(rd_b), .data_in(din_b),
    .data_out(dout_b), .empty(empty_b), .full(full_b), .almost_empty(ae_b),
    .almost_full(af_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr = w; rd = r; clear = c; data_in = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clear = 1'b0;
  endtask

  task automatic push_a(input logic [7:0] d);
    q_a.push_back(d);
    step_a(1'b1, 1'b0, 1'b0, d);
    chk("push_count", 32'(count), 32'(q_a.size()));
  endtask

  task automatic pop_a();
    chk("pop_head", 32'(data_out), 32'(q_a[0]));
    void'(q_a.pop_front());
    step_a(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pop_count", 32'(count), 32'(q_a.size()));
  endtask

  task automatic both_a(input logic [7:0] d);
    chk("both_head", 32'(data_out), 32'(q_a[0]));
    void'(q_a.pop_front());
    q_a.push_back(d);
    step_a(1'b1, 1'b1, 1'b0, d);
    chk("both_count", 32'(count), 32'(q_a.size()));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_af"}, 32'(almost_full), 32'd0);
    chk({tag, "_dout"}, 32'(data_out), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_udf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    logic m_full, m_empty, m_rd_ok, m_wr_ok, m_ovf, m_udf;
    reset = 1'b1; clear = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
    clear_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; din_b = '0;
    #1;
    chk_reset_state("rst0");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Fill 0x01..0x08 with threshold checks along the way.
    for (int i = 1; i <= 8; i++) begin
      push_a(8'(i));
      chk("fill_af", 32'(almost_full), 32'(i >= 6));
      chk("fill_ae", 32'(almost_empty), 32'(i <= 2));
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_head", 32'(data_out), 32'h01);
    step_a(1'b1, 1'b0, 1'b0, 8'h09);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);

    // Drain and underflow.
    for (int i = 1; i <= 8; i++) pop_a();
    chk("drain_empty", 32'(empty), 32'd1);
    step_a(1'b0, 1'b1, 1'b0, 8'h00);
    chk("udf_set", 32'(underflow), 32'd1);
    chk("udf_count", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous wr/rd at empty then at full.
    q_a.push_back(8'h55);
    step_a(1'b1, 1'b1, 1'b0, 8'h55);
    chk("empty_wrrd_count", 32'(count), 32'd1);
    chk("empty_wrrd_dout", 32'(data_out), 32'h55);
    chk("empty_wrrd_udf", 32'(underflow), 32'd1);
    for (int i = 1; i <= 7; i++) push_a(8'(8'h60 + i));
    chk("refull", 32'(full), 32'd1);
    both_a(8'hAA);
    chk("full_wrrd_full", 32'(full), 32'd1);
    for (int i = 0; i < 7; i++) pop_a();
    chk("last_is_aa", 32'(data_out), 32'hAA);
    pop_a();
    chk("boundary_empty", 32'(empty), 32'd1);

    // 20-word stream held at count 3 across pointer wrap, then almost_full edges.
    push_a(8'h10);
    push_a(8'h11);
    chk("ae_at2", 32'(almost_empty), 32'd1);
    push_a(8'h12);
    chk("ae_at3", 32'(almost_empty), 32'd0);
    for (int i = 3; i < 20; i++) begin
      both_a(8'(8'h10 + i));
      chk("stream_ae", 32'(almost_empty), 32'd0);
      chk("stream_af", 32'(almost_full), 32'd0);
    end
    push_a(8'h24);
    push_a(8'h25);
    chk("af_at5", 32'(almost_full), 32'd0);
    push_a(8'h26);
    chk("af_at6", 32'(almost_full), 32'd1);
    pop_a();
    chk("af_back5", 32'(almost_full), 32'd0);
    while (q_a.size() > 0) pop_a();

    // Flush with a concurrent write.
    for (int i = 0; i < 5; i++) push_a(8'(8'hC0 + i));
    chk("pre_clear_ovf", 32'(overflow), 32'd1);
    step_a(1'b1, 1'b0, 1'b1, 8'hEE);
    q_a.delete();
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_udf", 32'(underflow), 32'd0);
    step_a(1'b0, 1'b0, 1'b0, 8'h00);
    chk("clr_no_write", 32'(count), 32'd0);
    chk("clr_no_ee", 32'(data_out == 8'hEE), 32'd0);

    // Reload, then async reset between edges.
    for (int i = 0; i < 4; i++) push_a(8'(8'hD0 + i));
    chk("reload_head", 32'(data_out), 32'hD0);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_state("async_rst");
    q_a.delete();
    @(posedge clk); #1;
    reset = 1'b0;

    // Random traffic on the 16x32 instance against a queue model.
    m_ovf = 1'b0; m_udf = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 200) begin
        wr_b = ($urandom_range(0, 3) != 0); rd_b = ($urandom_range(0, 3) == 0);
      end else if (cyc < 400) begin
        wr_b = ($urandom_range(0, 3) == 0); rd_b = ($urandom_range(0, 3) != 0);
      end else begin
        wr_b = 1'($urandom_range(0, 1)); rd_b = 1'($urandom_range(0, 1));
      end
      din_b = 16'($urandom);
      m_full  = (q_b.size() == 32);
      m_empty = (q_b.size() == 0);
      m_rd_ok = rd_b & ~m_empty;
      m_wr_ok = wr_b & (~m_full | m_rd_ok);
      if (m_rd_ok) void'(q_b.pop_front());
      if (m_wr_ok) q_b.push_back(din_b);
      if (wr_b && !m_wr_ok) m_ovf = 1'b1;
      if (rd_b && m_empty) m_udf = 1'b1;
      @(posedge clk); #1;
      wr_b = 1'b0; rd_b = 1'b0;
      chk("b_count", 32'(count_b), 32'(q_b.size()));
      chk("b_full", 32'(full_b), 32'(q_b.size() == 32));
      chk("b_empty", 32'(empty_b), 32'(q_b.size() == 0));
      chk("b_af", 32'(af_b), 32'(q_b.size() >= 30));
      chk("b_ae", 32'(ae_b), 32'(q_b.size() <= 1));
      chk("b_ovf", 32'(ovf_b), 32'(m_ovf));
      chk("b_udf", 32'(udf_b), 32'(m_udf));
      if (q_b.size() > 0) chk("b_dout", 32'(dout_b), 32'(q_b[0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
